// File: rtl/dac_sweep_pkg.sv
// Shared definitions for the DAC staircase sweep sequencer.
// State encoding, default widths and the full-scale code.
package dac_sweep_pkg;

   localparam int DATA_W_DEF  = 12;
   localparam int DWELL_W_DEF = 16;

   localparam logic [DATA_W_DEF-1:0] FULL_SCALE = {DATA_W_DEF{1'b1}};

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      WAIT_EOD,
      DWELL,
      STEP_CHK,
      DONE
   } state_t;

endpackage

// File: rtl/dac_sweep_gen_dwell_cnt.sv
// Loadable down-counter that times the hold after each DAC transfer.
// The zero flag is high whenever the count has reached zero.
module dwell_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_value,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (en && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/dac_sweep_gen.sv
// Staircase bias sweep sequencer feeding the two-channel SPI DAC writer.
// Define DAC_SWEEP_TRIANGLE_EN to add a descending leg back to the start code.
module dac_sweep_gen
   import dac_sweep_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int DWELL_W = DWELL_W_DEF
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               stop_i,
   input  logic [DATA_W-1:0]  cfg_start_code_i,
   input  logic [DATA_W-1:0]  cfg_stop_code_i,
   input  logic [DATA_W-1:0]  cfg_step_i,
   input  logic [DWELL_W-1:0] cfg_dwell_i,
   input  logic               dac_eod_i,
   output logic [DATA_W-1:0]  cha_code_o,
   output logic [DATA_W-1:0]  chb_code_o,
   output logic               dac_start_o,
   output logic               busy_o,
   output logic               done_o
);

   localparam logic [DATA_W-1:0] CODE_FULL = {DATA_W{1'b1}};

   state_t state, next_state;

   logic [DATA_W-1:0]  stop_q, step_q;
   logic [DWELL_W-1:0] dwell_q;
   logic               abort_q;
   logic               launch, load_code, dwell_load, dwell_en, dwell_zero;
   logic [DATA_W-1:0]  code_next;
   logic [DATA_W:0]    up_sum;
   logic               up_last;
`ifdef DAC_SWEEP_TRIANGLE_EN
   logic [DATA_W-1:0]  start_q;
   logic               dir_down, set_down, down_last;
   logic [DATA_W:0]    down_diff;
`endif

   dwell_cnt #(.W(DWELL_W)) u_dwell (
      .clk        (clk_i),
      .rst_n      (rst_i),
      .load       (dwell_load),
      .en         (dwell_en),
      .load_value (dwell_q - DWELL_W'(1)),
      .zero       (dwell_zero)
   );

   // The extra carry bit catches a next code that would wrap past full scale.
   always_comb begin
      up_sum  = {1'b0, cha_code_o} + {1'b0, step_q};
      up_last = up_sum[DATA_W] || (up_sum[DATA_W-1:0] > stop_q) || (step_q == '0);
`ifdef DAC_SWEEP_TRIANGLE_EN
      down_diff = {1'b0, cha_code_o} - {1'b0, step_q};
      down_last = down_diff[DATA_W] || (down_diff[DATA_W-1:0] < start_q) || (step_q == '0);
`endif
   end

   always_comb begin
      next_state = state;
      launch     = 1'b0;
      load_code  = 1'b0;
      code_next  = cha_code_o;
      dwell_load = 1'b0;
      dwell_en   = 1'b0;
`ifdef DAC_SWEEP_TRIANGLE_EN
      set_down   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (start_i && !stop_i) begin
               next_state = SEND;
               launch     = 1'b1;
               load_code  = 1'b1;
               code_next  = cfg_start_code_i;
            end
         end
         SEND: next_state = WAIT_EOD;
         WAIT_EOD: begin
            if (dac_eod_i) begin
               if (abort_q || stop_i) begin
                  next_state = DONE;
               end else if (dwell_q != '0) begin
                  next_state = DWELL;
                  dwell_load = 1'b1;
               end else begin
                  next_state = STEP_CHK;
               end
            end
         end
         DWELL: begin
            if (stop_i) begin
               next_state = DONE;
            end else begin
               dwell_en = 1'b1;
               if (dwell_zero) next_state = STEP_CHK;
            end
         end
         STEP_CHK: begin
            next_state = DONE;
            if (!stop_i) begin
`ifdef DAC_SWEEP_TRIANGLE_EN
               if (!dir_down && !up_last) begin
                  next_state = SEND;
                  load_code  = 1'b1;
                  code_next  = up_sum[DATA_W-1:0];
               end else if (!down_last) begin
                  next_state = SEND;
                  load_code  = 1'b1;
                  code_next  = down_diff[DATA_W-1:0];
                  set_down   = 1'b1;
               end
`else
               if (!up_last) begin
                  next_state = SEND;
                  load_code  = 1'b1;
                  code_next  = up_sum[DATA_W-1:0];
               end
`endif
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= IDLE;
      else        state <= next_state;
   end

   // A stop seen while a transfer is in flight is remembered until its eod.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stop_q      <= '0;
         step_q      <= '0;
         dwell_q     <= '0;
         abort_q     <= 1'b0;
         cha_code_o  <= '0;
         chb_code_o  <= CODE_FULL;
         dac_start_o <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
`ifdef DAC_SWEEP_TRIANGLE_EN
         start_q     <= '0;
         dir_down    <= 1'b0;
`endif
      end else begin
         if (launch) begin
            stop_q  <= cfg_stop_code_i;
            step_q  <= cfg_step_i;
            dwell_q <= cfg_dwell_i;
`ifdef DAC_SWEEP_TRIANGLE_EN
            start_q  <= cfg_start_code_i;
            dir_down <= 1'b0;
`endif
         end
`ifdef DAC_SWEEP_TRIANGLE_EN
         if (set_down) dir_down <= 1'b1;
`endif
         if (load_code) begin
            cha_code_o <= code_next;
            chb_code_o <= CODE_FULL - code_next;
         end
         if (state == IDLE) begin
            abort_q <= 1'b0;
         end else if (((state == SEND) || (state == WAIT_EOD)) && stop_i) begin
            abort_q <= 1'b1;
         end
         dac_start_o <= (state == SEND);
         busy_o      <= (next_state != IDLE);
         done_o      <= (next_state == DONE);
      end
   end

endmodule

// File: tb/tb_dac_sweep_gen.sv
// Self-checking bench for dac_sweep_gen: table vectors, random sweeps and corner sequences.
// Expected code lists come from a plain-arithmetic sweep model (triangle leg under DAC_SWEEP_TRIANGLE_EN).
module tb_dac_sweep_gen;
   import dac_sweep_pkg::*;

   localparam int DW   = 12;
   localparam int WW   = 16;
   localparam int FULL = int'(FULL_SCALE);
`ifdef DAC_SWEEP_TRIANGLE_EN
   localparam bit TRI = 1'b1;
`else
   localparam bit TRI = 1'b0;
`endif

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b0;
   logic          start_i = 1'b0;
   logic          stop_i = 1'b0;
   logic [DW-1:0] cfg_start_code_i = '0;
   logic [DW-1:0] cfg_stop_code_i = '0;
   logic [DW-1:0] cfg_step_i = '0;
   logic [WW-1:0] cfg_dwell_i = '0;
   logic          dac_eod_i = 1'b0;
   logic [DW-1:0] cha_code_o, chb_code_o;
   logic          dac_start_o, busy_o, done_o;

   dac_sweep_gen #(.DATA_W(DW), .DWELL_W(WW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
      .cfg_start_code_i(cfg_start_code_i), .cfg_stop_code_i(cfg_stop_code_i),
      .cfg_step_i(cfg_step_i), .cfg_dwell_i(cfg_dwell_i), .dac_eod_i(dac_eod_i),
      .cha_code_o(cha_code_o), .chb_code_o(chb_code_o), .dac_start_o(dac_start_o),
      .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int s, e, st, dw, eod, n_up, last_up;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   int obs_q[$];
   int pulse_count, done_count, eod_iter, done_iter;

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // Reference: every code reached by stepping from start while <= stop and
   // representable, then (triangle) back down while >= start.
   function automatic void build_model(input int s, input int e, input int st);
      int c;
      exp_q.delete();
      c = s;
      exp_q.push_back(c);
      if (st != 0) begin
         while ((c + st <= e) && (c + st <= FULL)) begin
            c = c + st;
            exp_q.push_back(c);
         end
         if (TRI) begin
            while (c - st >= s) begin
               c = c - st;
               exp_q.push_back(c);
            end
         end
      end
   endfunction

   task automatic apply_stimulus(input int s, input int e, input int st, input int dw,
                                 input int eod_delay, input int abort_after,
                                 input int abort_delay, input bit poke_start);
      int  cd, it, since;
      bit  prev_start;
      cd = 0; it = 0; since = -1; prev_start = 1'b0;
      obs_q.delete();
      pulse_count = 0; done_count = 0; eod_iter = -1000; done_iter = -1;
      cfg_start_code_i = DW'(s);
      cfg_stop_code_i  = DW'(e);
      cfg_step_i       = DW'(st);
      cfg_dwell_i      = WW'(dw);
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      cfg_start_code_i = DW'($urandom);
      cfg_stop_code_i  = DW'($urandom);
      cfg_step_i       = DW'($urandom);
      cfg_dwell_i      = WW'($urandom_range(0, 9));
      while (1) begin
         if (cd > 0) begin
            cd--;
            dac_eod_i = (cd == 0);
            if (cd == 0) eod_iter = it;
         end else begin
            dac_eod_i = 1'b0;
         end
         if (dac_start_o) begin
            check_output("start_width", int'(prev_start), 0);
            check_output("chb_code", int'(chb_code_o), FULL - int'(cha_code_o));
            if (pulse_count > 0) check_output("dwell_gap", it - eod_iter, dw + 3);
            obs_q.push_back(int'(cha_code_o));
            pulse_count++;
            cd = eod_delay;
            since = 0;
         end
         prev_start = dac_start_o;
         if ((abort_after > 0) && (pulse_count == abort_after) && (since == abort_delay))
            stop_i = 1'b1;
         if (since >= 0) since++;
         if (done_o) begin
            done_count++;
            done_iter = it;
            stop_i = 1'b0;
         end
         start_i = (poke_start && (it == 25));
         if ((done_count > 0) && (it == done_iter + 1)) begin
            check_output("busy_after_done", int'(busy_o), 0);
            check_output("done_width", int'(done_o), 0);
            break;
         end
         if (it > 4000) begin
            check_output("sweep_timeout", 1, 0);
            break;
         end
         @(posedge clk_i); #1;
         it++;
      end
      dac_eod_i = 1'b0;
      stop_i    = 1'b0;
      start_i   = 1'b0;
   endtask

   task automatic compare_sweep(input string tag, input int dw, input bit aborted);
      int n;
      check_output({tag, "_points"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check_output($sformatf("%s_code%0d", tag, i), obs_q[i], exp_q[i]);
      check_output({tag, "_done_count"}, done_count, 1);
      check_output({tag, "_done_gap"}, done_iter - eod_iter, aborted ? 1 : dw + 2);
   endtask

   vec_t vecs[7];

   initial begin
      bit seen;
      int n_exp, last_exp;
      vecs[0] = '{100,  130,  10,   3, 20, 4, 130};
      vecs[1] = '{100,  125,  10,   0,  4, 3, 120};
      vecs[2] = '{200,  4095, 0,    2,  3, 1, 200};
      vecs[3] = '{300,  100,  10,   1,  5, 1, 300};
      vecs[4] = '{4090, 4095, 8,    0,  2, 1, 4090};
      vecs[5] = '{0,    4095, 1024, 0,  1, 4, 3072};
      vecs[6] = '{4000, 4095, 95,   1,  6, 2, 4095};

      #12;
      check_output("reset_cha", int'(cha_code_o), 0);
      check_output("reset_chb", int'(chb_code_o), FULL);
      check_output("reset_start", int'(dac_start_o), 0);
      check_output("reset_busy", int'(busy_o), 0);
      check_output("reset_done", int'(done_o), 0);
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;

      // launch latency: pulse appears on the second edge after start
      cfg_start_code_i = 12'd100; cfg_stop_code_i = 12'd130;
      cfg_step_i = 12'd10; cfg_dwell_i = 16'd0;
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      check_output("latency_n1_start", int'(dac_start_o), 0);
      check_output("latency_n1_busy", int'(busy_o), 1);
      check_output("latency_n1_cha", int'(cha_code_o), 100);
      @(posedge clk_i); #1;
      check_output("latency_n2_start", int'(dac_start_o), 1);
      #2 rst_i = 1'b0;
      #1 check_output("latency_rst_start", int'(dac_start_o), 0);
      #4 rst_i = 1'b1;
      @(posedge clk_i); #1;

      for (int v = 0; v < 7; v++) begin
         build_model(vecs[v].s, vecs[v].e, vecs[v].st);
         apply_stimulus(vecs[v].s, vecs[v].e, vecs[v].st, vecs[v].dw, vecs[v].eod, 0, 0, v == 0);
         compare_sweep($sformatf("vec%0d", v), vecs[v].dw, 1'b0);
         n_exp    = TRI ? 2 * vecs[v].n_up - 1 : vecs[v].n_up;
         last_exp = TRI ? vecs[v].s : vecs[v].last_up;
         check_output($sformatf("vec%0d_pulses", v), pulse_count, n_exp);
         check_output($sformatf("vec%0d_last", v), int'(cha_code_o), last_exp);
         repeat (2) @(posedge clk_i);
         #1;
      end

      // abort during the second transfer
      build_model(100, 200, 10);
      while (exp_q.size() > 2) void'(exp_q.pop_back());
      apply_stimulus(100, 200, 10, 4, 20, 2, 5, 1'b0);
      compare_sweep("abort", 4, 1'b1);
      repeat (2) @(posedge clk_i);
      #1;

      // start and stop together in IDLE: stop wins
      start_i = 1'b1; stop_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0; stop_i = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (dac_start_o || busy_o) seen = 1'b1;
         @(posedge clk_i); #1;
      end
      check_output("start_stop_idle", int'(seen), 0);

      // reset while dwelling
      cfg_start_code_i = 12'd100; cfg_stop_code_i = 12'd200;
      cfg_step_i = 12'd10; cfg_dwell_i = 16'd40;
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (dac_start_o) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk_i); #1;
      end
      check_output("rst_dwell_launch", int'(seen), 1);
      repeat (3) @(posedge clk_i);
      #1 dac_eod_i = 1'b1;
      @(posedge clk_i);
      #1 dac_eod_i = 1'b0;
      repeat (10) @(posedge clk_i);
      #1 check_output("rst_dwell_busy_before", int'(busy_o), 1);
      #2 rst_i = 1'b0;
      #1;
      check_output("rst_dwell_cha", int'(cha_code_o), 0);
      check_output("rst_dwell_chb", int'(chb_code_o), FULL);
      check_output("rst_dwell_start", int'(dac_start_o), 0);
      check_output("rst_dwell_busy", int'(busy_o), 0);
      check_output("rst_dwell_done", int'(done_o), 0);
      #3 rst_i = 1'b1;
      @(posedge clk_i); #1;

      // randomized sweeps against the model
      for (int r = 0; r < 10; r++) begin
         int s, e, st, dw, ed;
         s  = $urandom_range(0, 4095);
         e  = $urandom_range(0, 4095);
         st = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(150, 2000);
         dw = $urandom_range(0, 5);
         ed = $urandom_range(1, 8);
         build_model(s, e, st);
         apply_stimulus(s, e, st, dw, ed, 0, 0, 1'b0);
         compare_sweep($sformatf("rnd%0d", r), dw, 1'b0);
         repeat (2) @(posedge clk_i);
         #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
